// File: rtl/cpu_pkg.sv
// Shared types for the byte-serial load/store CPU: opcodes, instruction
// types, controller states and the decoded instruction word layout.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_LW  = 3'd4,
      OP_SW  = 3'd5
   } op_e;

   typedef enum logic [3:0] {
      R_TYPE  = 4'h1,
      I_TYPE  = 4'h2,
      M_TYPE  = 4'h3,
      SYS_END = 4'hF
   } itype_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_F_LO,
      ST_F_HI,
      ST_F_RX,
      ST_EXEC,
      ST_M_LO,
      ST_M_HI,
      ST_S_LO,
      ST_S_HI,
      ST_L_RX,
      ST_HALT
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic [3:0] itype;
   } instr_t;

   // I and M words carry a trailing immediate word.
   function automatic logic has_imm(input logic [3:0] t);
      return (t == I_TYPE) || (t == M_TYPE);
   endfunction

endpackage

// File: rtl/cpu_core_register_file.sv
// Eight 16-bit registers: two combinational read ports, one synchronous
// write port; r0 is hard-wired to zero.
module register_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  ra1,
   input  logic [2:0]  ra2,
   output logic [15:0] rd1,
   output logic [15:0] rd2,
   input  logic        we,
   input  logic [2:0]  wa,
   input  logic [15:0] wd
);

   logic [15:0] reg_file [8];

   // NOTE: this array is reset because software relies on every register
   // starting at zero; larger RAM-style arrays would normally be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) reg_file[i] <= '0;
      end else if (we && (wa != 3'd0)) begin
         reg_file[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 3'd0) ? 16'h0000 : reg_file[ra1];
   assign rd2 = (ra2 == 3'd0) ? 16'h0000 : reg_file[ra2];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 16-bit load/store core; every fetch and data access travels
// over a byte-serial link to an external agent holding both memories.
module cpu_core
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ard_receive_ready,
   input  logic       ard_data_ready,
   input  logic [7:0] in_bus,
   output logic [7:0] out_bus,
   output logic       bus_pc,
   output logic       bus_mar,
   output logic       bus_mdr,
   output logic       halt
);

   state_e      state, state_nxt;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] imm;
   instr_t      dec;
   logic [1:0]  rx_cnt;
   logic        rx_last;
   logic        mem_pending;
   logic        mem_store;
   logic [15:0] mem_addr;
   logic [15:0] store_data;
   logic [7:0]  load_lo;
   logic [2:0]  load_rd;
   logic [15:0] rs1_data, rs2_data;
   logic [15:0] alu_a, alu_b, alu_y;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;

   assign dec = instr_t'(ir);

   register_file rf (
      .clk (clk),
      .rst (rst),
      .ra1 (dec.rs1),
      .ra2 (dec.rs2),
      .rd1 (rs1_data),
      .rd2 (rs2_data),
      .we  (rf_we),
      .wa  (rf_waddr),
      .wd  (rf_wdata)
   );

   // The byte count decides when a receive phase ends; the instruction type
   // is already known once the low instruction byte has been captured.
   always_comb begin
      rx_last = 1'b0;
      if (state == ST_F_RX)
         rx_last = ard_data_ready &&
                   ((rx_cnt == 2'd3) || ((rx_cnt == 2'd1) && !has_imm(dec.itype)));
      else if (state == ST_L_RX)
         rx_last = ard_data_ready && (rx_cnt == 2'd1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      out_bus   = 8'h00;
      bus_pc    = 1'b0;
      bus_mar   = 1'b0;
      bus_mdr   = 1'b0;
      halt      = 1'b0;
      case (state)
         ST_IDLE: if (ard_receive_ready) state_nxt = mem_pending ? ST_M_LO : ST_F_LO;
         ST_F_LO: begin
            bus_pc    = 1'b1;
            out_bus   = pc[7:0];
            state_nxt = ST_F_HI;
         end
         ST_F_HI: begin
            bus_pc    = 1'b1;
            out_bus   = pc[15:8];
            state_nxt = ST_F_RX;
         end
         ST_F_RX: if (rx_last) state_nxt = ST_EXEC;
         ST_EXEC: begin
            case (dec.itype)
               R_TYPE, I_TYPE, M_TYPE: state_nxt = ST_IDLE;
               default:                state_nxt = ST_HALT;
            endcase
         end
         ST_M_LO: begin
            bus_mar   = 1'b1;
            bus_mdr   = mem_store;
            out_bus   = mem_addr[7:0];
            state_nxt = ST_M_HI;
         end
         ST_M_HI: begin
            bus_mar   = 1'b1;
            bus_mdr   = mem_store;
            out_bus   = mem_addr[15:8];
            state_nxt = mem_store ? ST_S_LO : ST_L_RX;
         end
         ST_S_LO: begin
            bus_mar   = 1'b1;
            bus_mdr   = 1'b1;
            out_bus   = store_data[7:0];
            state_nxt = ST_S_HI;
         end
         ST_S_HI: begin
            bus_mar   = 1'b1;
            bus_mdr   = 1'b1;
            out_bus   = store_data[15:8];
            state_nxt = ST_IDLE;
         end
         ST_L_RX: if (rx_last) state_nxt = ST_IDLE;
         ST_HALT: halt = 1'b1;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // For I-type the immediate is operand A, so SUB computes imm - rs1.
   always_comb begin
      alu_a = (dec.itype == I_TYPE) ? imm : rs1_data;
      alu_b = (dec.itype == I_TYPE) ? rs1_data : rs2_data;
      alu_y = 16'h0000;
      case (dec.op)
         OP_ADD:  alu_y = alu_a + alu_b;
         OP_SUB:  alu_y = alu_a - alu_b;
         OP_AND:  alu_y = alu_a & alu_b;
         OP_OR:   alu_y = alu_a | alu_b;
         default: alu_y = 16'h0000;
      endcase
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = dec.rd;
      rf_wdata = alu_y;
      if ((state == ST_EXEC) && ((dec.itype == R_TYPE) || (dec.itype == I_TYPE))) begin
         rf_we = 1'b1;
      end else if ((state == ST_L_RX) && rx_last) begin
         rf_we    = 1'b1;
         rf_waddr = load_rd;
         rf_wdata = {in_bus, load_lo};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         ir          <= '0;
         imm         <= '0;
         rx_cnt      <= '0;
         mem_pending <= 1'b0;
         mem_store   <= 1'b0;
         mem_addr    <= '0;
         store_data  <= '0;
         load_lo     <= '0;
         load_rd     <= '0;
      end else begin
         if ((state != ST_F_RX) && (state != ST_L_RX)) rx_cnt <= '0;
         else if (ard_data_ready)                      rx_cnt <= rx_cnt + 2'd1;

         case (state)
            ST_F_RX: begin
               if (ard_data_ready) begin
                  case (rx_cnt)
                     2'd0:    ir[7:0]   <= in_bus;
                     2'd1:    ir[15:8]  <= in_bus;
                     2'd2:    imm[7:0]  <= in_bus;
                     default: imm[15:8] <= in_bus;
                  endcase
               end
            end
            ST_EXEC: begin
               if (dec.itype == R_TYPE)     pc <= pc + 16'd1;
               else if (has_imm(dec.itype)) pc <= pc + 16'd2;
               // Store data is latched now so the write phase never rereads rs1.
               if ((dec.itype == M_TYPE) && ((dec.op == OP_LW) || (dec.op == OP_SW))) begin
                  mem_pending <= 1'b1;
                  mem_store   <= (dec.op == OP_SW);
                  mem_addr    <= imm;
                  store_data  <= rs1_data;
                  load_rd     <= dec.rd;
               end
            end
            ST_L_RX: begin
               if (ard_data_ready) begin
                  if (rx_cnt == 2'd0) load_lo     <= in_bus;
                  else                mem_pending <= 1'b0;
               end
            end
            ST_S_HI: mem_pending <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a byte-serial agent task serves fetches,
// loads and stores from separate instruction and data memories.
module tb_cpu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       ard_receive_ready;
   logic       ard_data_ready;
   logic [7:0] in_bus;
   logic [7:0] out_bus;
   logic       bus_pc;
   logic       bus_mar;
   logic       bus_mdr;
   logic       halt;

   always #5 clk = ~clk;

   cpu_core cpu (
      .clk               (clk),
      .rst               (rst),
      .ard_receive_ready (ard_receive_ready),
      .ard_data_ready    (ard_data_ready),
      .in_bus            (in_bus),
      .out_bus           (out_bus),
      .bus_pc            (bus_pc),
      .bus_mar           (bus_mar),
      .bus_mdr           (bus_mdr),
      .halt              (halt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   logic [15:0] imem [65536];
   logic [15:0] dmem [65536];
   int          fetch_cyc [$];
   logic [15:0] fetch_addr [$];
   int          pc_cycles, mar_cycles, mdr_cycles;
   logic [15:0] m_addr;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
      check(tag, cpu.rf.reg_file[idx], exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) begin
         imem[i] = 16'h0000;
         dmem[i] = 16'h0000;
      end
      fetch_cyc.delete();
      fetch_addr.delete();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      ard_data_ready = 1'b0;
      in_bus         = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int waits);
      repeat (waits) begin
         ard_data_ready = 1'b0;
         in_bus         = 8'h00;
         @(negedge clk);
      end
      ard_data_ready = 1'b1;
      in_bus         = b;
      @(negedge clk);
   endtask

   // Serves one complete bus request; called and returning at a negedge.
   task automatic transact(input int waits);
      int          n;
      int          nb;
      logic [15:0] a, w, w1, d;
      logic        st;
      n = 0;
      while (!bus_pc && !bus_mar && !halt && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("bus_request_timeout", 16'(n), 16'd39);
      if (halt || n >= 40) return;
      if (bus_pc) begin
         fetch_cyc.push_back(cyc);
         pc_cycles = 0;
         a[7:0] = out_bus;  pc_cycles += int'(bus_pc); @(negedge clk);
         a[15:8] = out_bus; pc_cycles += int'(bus_pc); @(negedge clk);
         pc_cycles += int'(bus_pc);
         fetch_addr.push_back(a);
         w  = imem[a];
         w1 = imem[a + 16'd1];
         nb = ((w[3:0] == 4'h2) || (w[3:0] == 4'h3)) ? 4 : 2;
         for (int i = 0; i < nb; i++) begin
            logic [7:0] b;
            case (i)
               0:       b = w[7:0];
               1:       b = w[15:8];
               2:       b = w1[7:0];
               default: b = w1[15:8];
            endcase
            send_byte(b, (i == 0) ? 0 : waits);
         end
         ard_data_ready = 1'b0;
         in_bus         = 8'h00;
      end else begin
         mar_cycles = 0;
         mdr_cycles = 0;
         a[7:0] = out_bus;  mar_cycles += int'(bus_mar); mdr_cycles += int'(bus_mdr); @(negedge clk);
         a[15:8] = out_bus; mar_cycles += int'(bus_mar); mdr_cycles += int'(bus_mdr);
         st = bus_mdr;
         @(negedge clk);
         m_addr = a;
         if (st) begin
            d[7:0] = out_bus;  mar_cycles += int'(bus_mar); mdr_cycles += int'(bus_mdr); @(negedge clk);
            d[15:8] = out_bus; mar_cycles += int'(bus_mar); mdr_cycles += int'(bus_mdr); @(negedge clk);
            mar_cycles += int'(bus_mar);
            mdr_cycles += int'(bus_mdr);
            dmem[a] = d;
         end else begin
            mar_cycles += int'(bus_mar);
            mdr_cycles += int'(bus_mdr);
            d = dmem[a];
            send_byte(d[7:0], 0);
            send_byte(d[15:8], waits);
            ard_data_ready = 1'b0;
            in_bus         = 8'h00;
         end
      end
   endtask

   task automatic run_prog(input int max_tx, input int waits);
      for (int i = 0; i < max_tx && !halt; i++) transact(waits);
   endtask

   task automatic load_add_prog();
      imem[0] = 16'h0402; imem[1] = 16'd5;    // I-ADD r1 <- 5
      imem[2] = 16'h0802; imem[3] = 16'd6;    // I-ADD r2 <- 6
      imem[4] = 16'h0CA1;                     // R-ADD r3 = r1 + r2
      imem[5] = 16'hA183; imem[6] = 16'd4;    // SW r3 -> [4]
      imem[7] = 16'h0002; imem[8] = 16'd7;    // I-ADD r0 <- 7 (discarded)
      imem[9] = 16'h1011;                     // R-ADD r4 = r0 + r1
      imem[10] = 16'h000F;                    // SYS_END
   endtask

   initial begin
      ard_receive_ready = 1'b1;
      ard_data_ready    = 1'b0;
      in_bus            = 8'h00;
      rst               = 1'b1;

      // Subtract sequence with store/load round trip and latency checks.
      clear_mem();
      imem[0] = 16'h2402; imem[1] = 16'd5;    // I-SUB r1 <- 5 - r0
      imem[2] = 16'h2802; imem[3] = 16'd6;    // I-SUB r2 <- 6 - r0
      imem[4] = 16'h2CA1;                     // R-SUB r3 = r1 - r2
      imem[5] = 16'hA183; imem[6] = 16'd4;    // SW r3 -> [4]
      imem[7] = 16'h8803; imem[8] = 16'd4;    // LW r2 <- [4]
      imem[9] = 16'h000F;                     // SYS_END
      do_reset();
      check("reset_out_bus", {8'h00, out_bus}, 16'h0000);
      check("reset_bus_pc",  {15'd0, bus_pc},  16'h0000);
      check("reset_bus_mar", {15'd0, bus_mar}, 16'h0000);
      check("reset_bus_mdr", {15'd0, bus_mdr}, 16'h0000);
      check("reset_halt",    {15'd0, halt},    16'h0000);
      for (int r = 1; r < 8; r++) check_reg("reset_reg", 3'(r), 16'h0000);
      run_prog(20, 0);
      check("sub_halt",    {15'd0, halt},    16'h0001);
      check("sub_mem4",    dmem[4],          16'hFFFF);
      check_reg("sub_r1",  3'd1,             16'h0005);
      check_reg("sub_r2",  3'd2,             16'hFFFF);
      check_reg("sub_r3",  3'd3,             16'hFFFF);
      check("sub_fetches", 16'(fetch_cyc.size()), 16'd6);
      check("lat_i0",  16'(fetch_cyc[1] - fetch_cyc[0]), 16'd8);
      check("lat_i1",  16'(fetch_cyc[2] - fetch_cyc[1]), 16'd8);
      check("lat_r",   16'(fetch_cyc[3] - fetch_cyc[2]), 16'd6);
      check("lat_sw",  16'(fetch_cyc[4] - fetch_cyc[3]), 16'd13);
      check("lat_lw",  16'(fetch_cyc[5] - fetch_cyc[4]), 16'd13);
      repeat (4) @(negedge clk);
      check("halt_sticky", {15'd0, halt},   16'h0001);
      check("halt_no_req", {15'd0, bus_pc}, 16'h0000);

      // Add sequence, store, and r0 write discard / read-as-zero.
      clear_mem();
      load_add_prog();
      do_reset();
      run_prog(20, 0);
      check("add_mem4",   dmem[4], 16'd11);
      check_reg("add_r1", 3'd1,    16'd5);
      check_reg("add_r2", 3'd2,    16'd6);
      check_reg("add_r3", 3'd3,    16'd11);
      check_reg("add_r4", 3'd4,    16'd5);
      check_reg("add_r0", 3'd0,    16'd0);

      // Logic ops, I-SUB operand order, op 6 writes zero, M no-op skips its imm.
      clear_mem();
      imem[0]  = 16'h0402; imem[1]  = 16'd10;   // I-ADD r1 <- 10
      imem[2]  = 16'h0802; imem[3]  = 16'd10;   // I-ADD r2 <- 10
      imem[4]  = 16'h1802; imem[5]  = 16'h000C; // I-ADD r6 <- 12
      imem[6]  = 16'h4CA1;                      // R-AND r3 = r1 & r2
      imem[7]  = 16'hA183; imem[8]  = 16'd4;    // SW r3 -> [4]
      imem[9]  = 16'h6CA1;                      // R-OR  r3 = r1 | r2
      imem[10] = 16'h54E1;                      // R-AND r5 = r1 & r6
      imem[11] = 16'h7CE1;                      // R-OR  r7 = r1 | r6
      imem[12] = 16'h3082; imem[13] = 16'd3;    // I-SUB r4 <- 3 - r1
      imem[14] = 16'hC8E1;                      // op 6 R-type -> r2 = 0
      imem[15] = 16'h0003; imem[16] = 16'h1C81; // M no-op; imm must not execute
      imem[17] = 16'h000F;                      // SYS_END
      do_reset();
      run_prog(30, 0);
      check("logic_mem4",   dmem[4], 16'd10);
      check_reg("and_r3",   3'd3,    16'd10);
      check_reg("and_r5",   3'd5,    16'h0008);
      check_reg("or_r7",    3'd7,    16'h000E);
      check_reg("isub_r4",  3'd4,    16'hFFF9);
      check_reg("op6_r2",   3'd2,    16'h0000);
      check("logic_fetches",   16'(fetch_cyc.size()), 16'd12);
      check("mnop_next_fetch", fetch_addr[11],        16'd17);
      check("logic_halt",      {15'd0, halt},         16'h0001);

      // Three wait cycles between bytes; illegal type halts.
      clear_mem();
      imem[0] = 16'h0402; imem[1] = 16'h1234;   // I-ADD r1 <- 0x1234
      imem[2] = 16'hA083; imem[3] = 16'h0020;   // SW r1 -> [0x20]
      imem[4] = 16'h9403; imem[5] = 16'h0020;   // LW r5 <- [0x20]
      imem[6] = 16'h0004;                       // illegal type
      do_reset();
      run_prog(20, 3);
      check_reg("wait_r1",  3'd1,          16'h1234);
      check("wait_mem20",   dmem[16'h20],  16'h1234);
      check_reg("wait_r5",  3'd5,          16'h1234);
      check("illegal_halt", {15'd0, halt}, 16'h0001);

      // Reset in the middle of a fetch receive, then rerun from PC 0.
      clear_mem();
      load_add_prog();
      do_reset();
      transact(0);
      begin
         int n;
         n = 0;
         while (!bus_pc && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("midrst_fetch_seen", {15'd0, bus_pc}, 16'h0001);
      end
      @(negedge clk);
      @(negedge clk);
      send_byte(imem[2][7:0], 0);
      ard_data_ready = 1'b0;
      rst            = 1'b1;
      @(negedge clk);
      check("midrst_bus_pc",  {15'd0, bus_pc}, 16'h0000);
      check("midrst_out_bus", {8'h00, out_bus}, 16'h0000);
      check("midrst_halt",    {15'd0, halt},   16'h0000);
      check_reg("midrst_r1",  3'd1,            16'h0000);
      rst = 1'b0;
      fetch_cyc.delete();
      fetch_addr.delete();
      run_prog(20, 0);
      check("rerun_first_pc", fetch_addr[0], 16'h0000);
      check("rerun_mem4",     dmem[4],       16'd11);
      check_reg("rerun_r3",   3'd3,          16'd11);

      // Bus protocol at PC 0x1234: fetch address bytes and a store transfer.
      clear_mem();
      for (int a = 0; a < 16'h1234; a += 2) begin
         imem[a]     = 16'h0C02;                // I-ADD r3 <- 0xBEEF
         imem[a + 1] = 16'hBEEF;
      end
      imem[16'h1234] = 16'hA183; imem[16'h1235] = 16'h00A5; // SW r3 -> [0xA5]
      imem[16'h1236] = 16'h000F;
      do_reset();
      run_prog(2330, 0);
      check_reg("fill_r3", 3'd3, 16'hBEEF);
      fetch_addr.delete();
      transact(0);
      check("proto_fetch_addr", fetch_addr[0],       16'h1234);
      check("proto_bus_pc_len", 16'(pc_cycles),      16'd2);
      transact(0);
      check("proto_sw_addr",    m_addr,              16'h00A5);
      check("proto_mar_len",    16'(mar_cycles),     16'd4);
      check("proto_mdr_len",    16'(mdr_cycles),     16'd4);
      check("proto_sw_data",    dmem[16'h00A5],      16'hBEEF);
      run_prog(5, 0);
      check("proto_halt",       {15'd0, halt},       16'h0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cpu_core.md
# cpu_core

Multi-cycle 16-bit load/store CPU core with eight 16-bit registers. It has no local memory. Every instruction fetch and data access goes over an 8-bit byte-serial link to an external bus agent (a microcontroller) that holds both instruction and data memory. It executes R/I/M-type ALU and memory instructions until it decodes an end instruction, then raises `halt`.

## Interface
- No parameters.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ard_receive_ready`  in  1  agent can accept a new request; sampled only in IDLE.
- `ard_data_ready`  in  1  `in_bus` holds a valid byte this cycle.
- `in_bus`  in  8  response byte from the agent, low byte first.
- `out_bus`  out  8  request byte to the agent, low byte first.
- `bus_pc`  out  1  instruction-fetch request is active.
- `bus_mar`  out  1  data-address request is active.
- `bus_mdr`  out  1  the data request is a store; low means load.
- `halt`  out  1  end instruction executed; sticky until `rst`.

## Operation
- Instruction word fields: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] type.
- Op codes: ADD=0, SUB=1, AND=2, OR=3, LW=4, SW=5.
- Type codes: R=1, I=2, M=3, SYS_END=4'hF. Any other type also halts.
- I and M instructions are followed by one immediate word at PC+1.
- PC is a word address. It advances by 1 after R instructions and by 2 after I/M instructions, modulo 2^16.
- Register file: r0..r7. r0 reads as 0 and writes to it are discarded.
- R-type: rd = rs1 OP rs2.
- I-type: rd = imm OP rs1. The immediate is operand A, so SUB gives imm − rs1.
- Arithmetic is 16-bit two's complement with wrap-around. No flags are kept.
- M-type SW: mem[imm] = rs1. M-type LW: rd = mem[imm].
- An M word whose op is not LW or SW executes as a no-op.
- An R or I word whose op is 4..7 writes 0 to rd.
- FSM states:
  - IDLE: wait for `ard_receive_ready`, then go to F_LO for a fetch or to M_LO for a pending memory access.
  - F_LO, F_HI: send the PC.
  - F_RX: receive 2 bytes, or 4 bytes if the received type is I or M.
  - EXEC: execute the instruction.
  - M_LO, M_HI: send the address.
  - S_LO, S_HI: send store data (stores only).
  - L_RX: receive 2 bytes (loads only).
  - HALT.
- Transitions after EXEC:
  - R/I instructions, and M no-ops, go to IDLE.
  - LW and SW go to IDLE with a memory access pending.
  - SYS_END and illegal types go to HALT.
- Transitions after a memory access:
  - After S_HI, return to IDLE.
  - After the second L_RX byte, write rd, then return to IDLE.
- Reset values:
  - Outputs: `bus_pc`, `bus_mar`, `bus_mdr` and `halt` are 0; `out_bus` is 0.
  - Internal state: PC=0, all registers 0, state IDLE.
- `rst` asserted in any state, including mid-transfer, aborts the operation and restores the reset state on the next edge.

## Timing
- Fetch address phase:
  - `bus_pc` is high for exactly 2 cycles (F_LO, F_HI).
  - `out_bus` = PC[7:0], then PC[15:8].
- Data address phase:
  - `bus_mar` is high for exactly 2 cycles (M_LO, M_HI).
  - `out_bus` = addr[7:0], then addr[15:8].
- Store:
  - `bus_mdr` is high from M_LO through S_HI (4 cycles); `bus_mar` stays high through S_HI.
  - S_LO/S_HI drive data[7:0], then data[15:8].
- Load: `bus_mdr` stays 0.
- Receive (F_RX, L_RX):
  - Each cycle with `ard_data_ready`=1 captures one `in_bus` byte, LSB byte first.
  - Cycles with `ard_data_ready`=0 are waits with no timeout.
  - The byte count completes the phase.
- `out_bus` is 0 whenever no request is active.
- Minimum instruction latency (zero wait states, `ard_receive_ready` already high):
  - R: 1 (IDLE) + 2 (address) + 2 (receive) + 1 (EXEC) = 6 cycles.
  - I: 8 cycles.
  - SW: 8 + 1 (IDLE) + 4 = 13 cycles.
  - LW: 8 + 1 (IDLE) + 2 + 2 = 13 cycles.
- `halt` rises in the cycle after EXEC of SYS_END and stays high until reset.

## Structure
- Package `cpu_pkg`: op enum (ADD, SUB, AND, OR, LW, SW), type enum (R_TYPE, I_TYPE, M_TYPE, SYS_END), state enum.
- Sub-module `register_file`, instance name `rf`, array `reg_file[8]` of 16 bits:
  - Two combinational read ports and one synchronous write port.
  - r0 forced to 0.
  - The bench probes `cpu.rf.reg_file[n]`.
- The ALU is a combinational case statement inside `cpu_core`.

## Test plan
- Sequence: I-SUB r1←5, I-SUB r2←6, R-SUB r3=r1−r2, SW r3→[4], LW r2←[4], SYS_END.
  - Required: mem[4]=16'hFFFF, r2=16'hFFFF, `halt`=1.
- Sequence: I-ADD r1←5, I-ADD r2←6, R-ADD r3, SW [4].
  - Required: mem[4]=11, r1=5, r2=6, r3=11.
- R-AND with r1=r2=10 → r3=10, mem[4]=10. R-OR with the same values → r3=10.
- Bus protocol check at PC=0x1234:
  - `out_bus` = 0x34, then 0x12, with `bus_pc` high for 2 cycles.
  - SW check: `bus_mar` covers 2 address bytes plus 2 data bytes, with `bus_mdr` high throughout.
- Wait states: hold `ard_data_ready` low for 3 cycles between fetch bytes → instruction still correct.
- Assert `rst` mid-fetch → outputs are 0, PC=0, and a rerun from PC=0 gives correct results.
